// File: rtl/alu_pkg.sv
// Shared encodings between the control unit and the ALU: opcodes, ALU ops, FSM states.
package alu_pkg;

  localparam int unsigned INSTR_W  = 8;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned RADDR_W  = 2;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND  = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR   = 3'b011;
  localparam logic [OPC_W-1:0] OP_MOV  = 3'b100;
  localparam logic [OPC_W-1:0] OP_BEQ  = 3'b101;
  localparam logic [OPC_W-1:0] OP_BZ   = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_A = 3'b100;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]   op;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs;
    logic               spare;
  } instr_t;

endpackage

// File: rtl/decod_instr.sv
// Combinational instruction decoder: IR -> ALU op, register addresses and class flags.
module decod_instr
  import alu_pkg::*;
(
  input  logic [INSTR_W-1:0]  ir,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [RADDR_W-1:0]  rs_a,
  output logic [RADDR_W-1:0]  rs_b,
  output logic [RADDR_W-1:0]  rd_addr,
  output logic                is_alu,
  output logic                is_beq,
  output logic                is_bz,
  output logic                is_halt
);

  instr_t w_ir;
  logic   w_unused_spare;

  assign w_ir           = instr_t'(ir);
  assign w_unused_spare = w_ir.spare;

  always_comb begin
    alu_op  = ALU_SUB;
    rs_a    = w_ir.rd;
    rs_b    = w_ir.rs;
    rd_addr = w_ir.rd;
    is_alu  = 1'b0;
    is_beq  = 1'b0;
    is_bz   = 1'b0;
    is_halt = 1'b0;
    case (w_ir.op)
      OP_ADD:  begin alu_op = ALU_ADD; is_alu = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; is_alu = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; is_alu = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  is_alu = 1'b1; end
      // MOV passes rs through operand A so the ALU result is reg[rs]
      OP_MOV:  begin alu_op = ALU_PASS_A; rs_a = w_ir.rs; is_alu = 1'b1; end
      OP_BEQ:  is_beq  = 1'b1;
      OP_BZ:   is_bz   = 1'b1;
      default: is_halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the 8-bit ALU datapath: fetch/decode/exec/writeback FSM,
// program counter, instruction register and sticky zero flag.
module unidade_controle
  import alu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [PC_W-1:0]     pc,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic                alu_zero,
  input  logic                alu_eq,
  output logic [RADDR_W-1:0]  rs_a,
  output logic [RADDR_W-1:0]  rs_b,
  output logic [RADDR_W-1:0]  rd_addr,
  output logic                reg_we,
  output logic                flag_z,
  output logic                halted
);

  state_t               r_state;
  logic [PC_W-1:0]      r_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic                 r_flag_z;

  state_t               w_state_nxt;
  logic [PC_W-1:0]      w_pc_nxt;
  logic [INSTR_W-1:0]   w_ir_nxt;
  logic                 w_flag_z_nxt;
  logic                 w_instr_ready;
  logic                 w_reg_we;
  logic                 w_halted;

  logic                 w_is_alu;
  logic                 w_is_beq;
  logic                 w_is_bz;
  logic                 w_is_halt;

  decod_instr u_decod (
    .ir      (r_ir),
    .alu_op  (alu_op),
    .rs_a    (rs_a),
    .rs_b    (rs_b),
    .rd_addr (rd_addr),
    .is_alu  (w_is_alu),
    .is_beq  (w_is_beq),
    .is_bz   (w_is_bz),
    .is_halt (w_is_halt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_flag_z <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_flag_z <= w_flag_z_nxt;
    end
  end

  // Next-state and state-decoded strobes; reg_we is decoded from the state so reset cuts it at once
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_flag_z_nxt  = r_flag_z;
    w_instr_ready = 1'b0;
    w_reg_we      = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_instr_ready = 1'b1;
        if (instr_valid) begin
          w_ir_nxt    = instr;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_is_alu) begin
          w_flag_z_nxt = alu_zero;
          w_state_nxt  = ST_WB;
        end else if (w_is_beq) begin
          w_pc_nxt    = r_pc + (alu_eq ? PC_W'(2) : PC_W'(1));
          w_state_nxt = ST_FETCH;
        end else if (w_is_bz) begin
          // BZ tests the flag as it stood before this instruction
          w_pc_nxt    = r_pc + (r_flag_z ? PC_W'(2) : PC_W'(1));
          w_state_nxt = ST_FETCH;
        end else if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_WB: begin
        w_reg_we    = 1'b1;
        w_pc_nxt    = r_pc + PC_W'(1);
        w_state_nxt = ST_FETCH;
      end
      ST_HALT: w_halted = 1'b1;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  assign instr_ready = w_instr_ready;
  assign reg_we      = w_reg_we;
  assign halted      = w_halted;
  assign pc          = r_pc;
  assign flag_z      = r_flag_z;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed, table-driven bench for unidade_controle plus hand-written wrap/idle/halt/reset sequences.
module tb_unidade_controle;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] pc;
  logic [2:0] alu_op;
  logic       alu_zero;
  logic       alu_eq;
  logic [1:0] rs_a;
  logic [1:0] rs_b;
  logic [1:0] rd_addr;
  logic       reg_we;
  logic       flag_z;
  logic       halted;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] m_pc;

  typedef struct packed {
    logic [7:0] instr;
    logic       eq;
    logic       zero;
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rd;
    logic       wb;
    logic [7:0] pc;
    logic       fz;
  } vec_t;

  unidade_controle #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .alu_op      (alu_op),
    .alu_zero    (alu_zero),
    .alu_eq      (alu_eq),
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .rd_addr     (rd_addr),
    .reg_we      (reg_we),
    .flag_z      (flag_z),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] i, input logic eq, input logic z,
                              input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] rd, input logic wb, input logic [7:0] p,
                              input logic fz);
    vec_t v;
    v = '{instr: i, eq: eq, zero: z, op: op, a: a, b: b, rd: rd, wb: wb, pc: p, fz: fz};
    return v;
  endfunction

  // Issue one instruction from a FETCH negedge and follow it until the next FETCH
  task automatic run(input vec_t v, input string tag);
    int w;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".ready_wait"}, int'(instr_ready), 1);
    instr = v.instr; instr_valid = 1'b1; alu_eq = v.eq; alu_zero = v.zero;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 8'hFF;
    @(negedge clk);
    chk({tag, ".alu_op"}, int'(alu_op), int'(v.op));
    chk({tag, ".rs_a"}, int'(rs_a), int'(v.a));
    chk({tag, ".rs_b"}, int'(rs_b), int'(v.b));
    chk({tag, ".rdy_dec"}, int'(instr_ready), 0);
    chk({tag, ".we_dec"}, int'(reg_we), 0);
    @(negedge clk);
    chk({tag, ".we_exec"}, int'(reg_we), 0);
    if (v.wb) begin
      @(negedge clk);
      chk({tag, ".we_wb"}, int'(reg_we), 1);
      chk({tag, ".rd_wb"}, int'(rd_addr), int'(v.rd));
      chk({tag, ".rdy_wb"}, int'(instr_ready), 0);
    end
    @(negedge clk);
    chk({tag, ".rdy_next"}, int'(instr_ready), 1);
    chk({tag, ".we_next"}, int'(reg_we), 0);
    chk({tag, ".pc"}, int'(pc), int'(v.pc));
    chk({tag, ".flag_z"}, int'(flag_z), int'(v.fz));
    m_pc = v.pc;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".pc"}, int'(pc), 0);
    chk({tag, ".ready"}, int'(instr_ready), 1);
    chk({tag, ".reg_we"}, int'(reg_we), 0);
    chk({tag, ".halted"}, int'(halted), 0);
    chk({tag, ".alu_op"}, int'(alu_op), 0);
    chk({tag, ".rs_a"}, int'(rs_a), 0);
    chk({tag, ".rs_b"}, int'(rs_b), 0);
    chk({tag, ".rd"}, int'(rd_addr), 0);
    chk({tag, ".flag_z"}, int'(flag_z), 0);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(8'h0C, 0, 0, 3'd0, 2'd1, 2'd2, 2'd1, 1, 8'h01, 0); // ADD r1,r2
    vecs[1]  = mk(8'h20, 0, 1, 3'd1, 2'd0, 2'd0, 2'd0, 1, 8'h02, 1); // SUB r0,r0 -> zero
    vecs[2]  = mk(8'hC0, 0, 0, 3'd1, 2'd0, 2'd0, 2'd0, 0, 8'h04, 1); // BZ taken
    vecs[3]  = mk(8'h56, 0, 0, 3'd2, 2'd2, 2'd3, 2'd2, 1, 8'h05, 0); // AND r2,r3
    vecs[4]  = mk(8'hC0, 0, 1, 3'd1, 2'd0, 2'd0, 2'd0, 0, 8'h06, 0); // BZ not taken
    vecs[5]  = mk(8'h7A, 0, 0, 3'd3, 2'd3, 2'd1, 2'd3, 1, 8'h07, 0); // OR r3,r1
    vecs[6]  = mk(8'h86, 0, 1, 3'd4, 2'd3, 2'd3, 2'd0, 1, 8'h08, 1); // MOV r0,r3
    vecs[7]  = mk(8'hAC, 1, 0, 3'd1, 2'd1, 2'd2, 2'd1, 0, 8'h0A, 1); // BEQ taken
    vecs[8]  = mk(8'hAC, 0, 1, 3'd1, 2'd1, 2'd2, 2'd1, 0, 8'h0B, 1); // BEQ not taken
    vecs[9]  = mk(8'hC0, 0, 0, 3'd1, 2'd0, 2'd0, 2'd0, 0, 8'h0D, 1); // BZ taken, flag held
    vecs[10] = mk(8'h2C, 0, 0, 3'd1, 2'd1, 2'd2, 2'd1, 1, 8'h0E, 0); // SUB nonzero
    vecs[11] = mk(8'hC0, 0, 1, 3'd1, 2'd0, 2'd0, 2'd0, 0, 8'h0F, 0); // BZ not taken
    vecs[12] = mk(8'h0D, 0, 0, 3'd0, 2'd1, 2'd2, 2'd1, 1, 8'h10, 0); // ADD, bit0 ignored

    rst_n = 1'b0; instr = 8'h00; instr_valid = 1'b0; alu_eq = 1'b0; alu_zero = 1'b0;
    m_pc = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset0");

    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

    // Step with untaken BZ up to the PC wrap boundary
    for (int i = 0; i < 300 && m_pc != 8'hFF; i++)
      run(mk(8'hC0, 0, 0, 3'd1, 2'd0, 2'd0, 2'd0, 0, m_pc + 8'd1, 0), "step_a");
    run(mk(8'hAC, 1, 0, 3'd1, 2'd1, 2'd2, 2'd1, 0, 8'h01, 0), "beq_wrap2");
    for (int i = 0; i < 300 && m_pc != 8'hFF; i++)
      run(mk(8'hC0, 0, 0, 3'd1, 2'd0, 2'd0, 2'd0, 0, m_pc + 8'd1, 0), "step_b");
    run(mk(8'hAC, 0, 0, 3'd1, 2'd1, 2'd2, 2'd1, 0, 8'h00, 0), "beq_wrap1");

    // Idle in FETCH: invalid instr must be ignored
    instr = 8'hE0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d.ready", i), int'(instr_ready), 1);
      chk($sformatf("idle%0d.pc", i), int'(pc), 0);
      chk($sformatf("idle%0d.alu_op", i), int'(alu_op), 1);
      chk($sformatf("idle%0d.rs_a", i), int'(rs_a), 1);
      chk($sformatf("idle%0d.halted", i), int'(halted), 0);
    end

    // HALT, then keep offering instructions
    instr = 8'hE0; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 8'h0C;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk($sformatf("halt_c%0d.ready", i), int'(instr_ready), 0);
      chk($sformatf("halt_c%0d.halted", i), int'(halted), 0);
    end
    for (int i = 3; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("halt_c%0d.halted", i), int'(halted), 1);
      chk($sformatf("halt_c%0d.ready", i), int'(instr_ready), 0);
      chk($sformatf("halt_c%0d.pc", i), int'(pc), 0);
      chk($sformatf("halt_c%0d.we", i), int'(reg_we), 0);
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst.halted", int'(halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset1");
    m_pc = 8'h00;

    // Reset asserted during WB of an ADD
    run(mk(8'h20, 0, 1, 3'd1, 2'd0, 2'd0, 2'd0, 1, 8'h01, 1), "pre_sub");
    instr = 8'h0C; instr_valid = 1'b1; alu_zero = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wbrst.we_before", int'(reg_we), 1);
    chk("wbrst.rd_before", int'(rd_addr), 1);
    rst_n = 1'b0;
    #1;
    chk("wbrst.we_cut", int'(reg_we), 0);
    chk("wbrst.pc_rst", int'(pc), 0);
    chk("wbrst.fz_rst", int'(flag_z), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset2");
    @(negedge clk);
    chk("wbrst.we_after", int'(reg_we), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
